mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit between EXMEM and MEMWB. Takes the EX-computed address, store data
//  and access size; runs a req/ack transaction on the data-memory bus; returns a byte-steered,
//  sign/zero-extended load word to MEMWB.memory_data_in. Stalls the pipeline while the bus is busy.
// PARAMETERS
//  DATA_W   32  data/address width (only 32 supported)
//  F3_W      3  width of funct3 size/sign field
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst_n        in   1   asynchronous, active-low reset
//  mem_read_i   in   1   EXMEM: load in MEM stage
//  mem_write_i  in   1   EXMEM: store in MEM stage
//  funct3_i     in   3   000 b, 001 h, 010 w, 100 bu, 101 hu
//  addr_i       in   32  EXMEM ALU_result (byte address)
//  wdata_i      in   32  EXMEM rs2 store value
//  bus_req_o    out  1   bus request, held until ack/err
//  bus_we_o     out  1   1 = write
//  bus_addr_o   out  32  word address ({addr[31:2],2'b00})
//  bus_wdata_o  out  32  lane-replicated store data
//  bus_wstrb_o  out  4   byte enables (0000 on reads)
//  bus_rdata_i  in   32  read word, valid with ack
//  bus_ack_i    in   1   transaction complete
//  bus_err_i    in   1   transaction failed (completes like ack)
//  load_data_o  out  32  extended load data to MEMWB
//  stall_o      out  1   hold IF..EXMEM this cycle
//  bus_err_o    out  1   one-cycle error pulse to hazard/trap logic
//  misalign_o   out  1   misaligned access flag (see CONFIGURATION)
// BEHAVIOUR
//  - FSM: IDLE -> BUS -> DONE -> IDLE. access = mem_read_i|mem_write_i (both high: store wins).
//  - IDLE: access -> BUS, registering req/we/addr/wdata/wstrb/funct3/addr[1:0]. stall_o=access.
//  - BUS: bus_req_o=1, bus_* stable; stall_o=1. ack|err -> DONE, capture rdata (err: capture 0,
//    set err flag). No ack -> stay, unbounded.
//  - DONE: bus_req_o=0; stall_o=0 so EXMEM/MEMWB advance at end of this cycle; load_data_o valid;
//    bus_err_o=err flag. -> IDLE unconditionally (EXMEM now holds the next instruction).
//  - Min latency: access seen cycle 0, req cycle 1, ack cycle 1, data/stall-low cycle 2.
//  - Store steering: sb wdata={4{b}}, wstrb=0001<<a[1:0]; sh wdata={2{h}}, wstrb=0011<<{a[1],1'b0};
//    sw wstrb=1111. Reserved funct3 (011/110/111) treated as word.
//  - Load extend: byte lane a[1:0], half lane a[1]; b/h sign-extend, bu/hu zero-extend.
//  - load_data_o holds last DONE value outside DONE; 0 for stores.
//  - ack/err seen in IDLE or DONE: ignored.
//  - Async reset (any state, incl. mid-BUS): state=IDLE, all outputs 0 immediately; a later ack
//    for the aborted transfer is ignored.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: h with a[0]=1 or w with a[1:0]!=0 skips BUS (IDLE->DONE, no
//    bus_req_o); DONE drives misalign_o=1, load_data_o=0, no write issued. stall_o=1 in IDLE cycle.
//  Not defined: misalign_o tied 0; offending low address bits ignored (h uses a[1], w uses none).
// STRUCTURE
//  Package rv32_mem_pkg: funct3 size codes (F3_LB..F3_LHU), FSM state enum, wstrb constants.
//  Sub-module lsu_align: combinational store steering + load extraction/extension; FSM, regs in top.
// TESTING
//  1 lw addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> req 3 cycles, stall 4 cycles, DONE
//    load_data 0xDEADBEEF, bus_addr 0x100, wstrb 0000.
//  2 lb addr 0x203, rdata 0x80xxxxxx -> 0xFFFFFF80; lbu same -> 0x00000080; lhu addr 0x202,
//    rdata 0xBEEFxxxx -> 0x0000BEEF.
//  3 sb 0x5A to 0x301 -> wdata 0x5A5A5A5A, wstrb 0010; sh to 0x302 -> wstrb 1100; sw -> 1111.
//  4 lw with bus_err_i on cycle 2 -> bus_err_o=1 for one cycle, load_data 0, stall drops in DONE.
//  5 rst_n low mid-BUS then ack -> req drops async, FSM IDLE, no DONE, stray ack ignored.
//  6 lw addr 0x102: with MEM_MISALIGN_TRAP_EN misalign_o=1, no req; without, req addr 0x100.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 size codes,
// FSM states, byte-enable constants and size/misalignment helpers.
package rv32_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [3:0] WSTRB_NONE = 4'b0000;
    localparam logic [3:0] WSTRB_B    = 4'b0001;
    localparam logic [3:0] WSTRB_H    = 4'b0011;
    localparam logic [3:0] WSTRB_W    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Reserved codes (011/110/111) fall through to word.
    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3_size(f3))
            SZ_H:    return lo[0];
            SZ_W:    return |lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/ack bus between the MEM-stage LSU (master) and memory (slave).
interface mem_stage_lsu_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              err;

    modport master (output req, we, addr, wdata, wstrb, input  rdata, ack, err);
    modport slave  (input  req, we, addr, wdata, wstrb, output rdata, ack, err);
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational store-lane steering and load-lane extraction with sign/zero extension.
module lsu_align
    import rv32_mem_pkg::*;
(
    input  logic [2:0]  i_st_f3,
    input  logic [1:0]  i_st_lo,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_st_data,
    output logic [3:0]  o_st_strb,
    input  logic [2:0]  i_ld_f3,
    input  logic [1:0]  i_ld_lo,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signed;

    always_comb begin
        o_st_data = i_st_data;
        o_st_strb = WSTRB_W;
        case (f3_size(i_st_f3))
            SZ_B: begin
                o_st_data = {4{i_st_data[7:0]}};
                o_st_strb = WSTRB_B << i_st_lo;
            end
            SZ_H: begin
                o_st_data = {2{i_st_data[15:0]}};
                o_st_strb = WSTRB_H << {i_st_lo[1], 1'b0};
            end
            default: ;
        endcase
    end

    assign w_byte   = i_ld_rdata[{i_ld_lo, 3'b000} +: 8];
    assign w_half   = i_ld_rdata[{i_ld_lo[1], 4'b0000} +: 16];
    assign w_signed = ~i_ld_f3[2];

    always_comb begin
        o_ld_data = i_ld_rdata;
        case (f3_size(i_ld_f3))
            SZ_B:    o_ld_data = {{24{w_signed & w_byte[7]}}, w_byte};
            SZ_H:    o_ld_data = {{16{w_signed & w_half[15]}}, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: IDLE -> BUS -> DONE req/ack sequencer with pipeline stall.
// Optional MEM_MISALIGN_TRAP_EN: misaligned h/w accesses skip the bus and flag misalign_o.
module mem_stage_lsu
    import rv32_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int F3_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [F3_W-1:0]   funct3_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    mem_stage_lsu_if.master   bus,
    output logic [DATA_W-1:0] load_data_o,
    output logic              stall_o,
    output logic              bus_err_o,
    output logic              misalign_o
);

    lsu_state_e        r_state, w_state_nxt;
    logic              r_we;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_wstrb;
    logic [F3_W-1:0]   r_f3;
    logic [1:0]        r_lo;
    logic              r_err;
    logic [DATA_W-1:0] r_load;

    logic              w_access;
    logic              w_mis;
    logic              w_stall;
    logic              w_bus_done;
    logic [DATA_W-1:0] w_st_data;
    logic [3:0]        w_st_strb;
    logic [DATA_W-1:0] w_ld_data;

    assign w_access   = mem_read_i | mem_write_i;
    assign w_bus_done = bus.ack | bus.err;

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_mis;
    assign w_mis      = is_misaligned(funct3_i, addr_i[1:0]);
    assign misalign_o = (r_state == ST_DONE) & r_mis;
`else
    assign w_mis      = 1'b0;
    assign misalign_o = 1'b0;
`endif

    lsu_align u_align (
        .i_st_f3    (funct3_i),
        .i_st_lo    (addr_i[1:0]),
        .i_st_data  (wdata_i),
        .o_st_data  (w_st_data),
        .o_st_strb  (w_st_strb),
        .i_ld_f3    (r_f3),
        .i_ld_lo    (r_lo),
        .i_ld_rdata (bus.rdata),
        .o_ld_data  (w_ld_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall = w_access;
                if (w_access) w_state_nxt = w_mis ? ST_DONE : ST_BUS;
            end
            ST_BUS: begin
                w_stall = 1'b1;
                if (w_bus_done) w_state_nxt = ST_DONE;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= WSTRB_NONE;
            r_f3    <= '0;
            r_lo    <= 2'b00;
            r_err   <= 1'b0;
            r_load  <= '0;
        end else begin
            if (r_state == ST_IDLE && w_access) begin
                r_we    <= mem_write_i;
                r_addr  <= {addr_i[DATA_W-1:2], 2'b00};
                r_wdata <= w_st_data;
                r_wstrb <= mem_write_i ? w_st_strb : WSTRB_NONE;
                r_f3    <= funct3_i;
                r_lo    <= addr_i[1:0];
                r_err   <= 1'b0;
                if (w_mis) r_load <= '0;
            end
            // Extension is folded in at capture so load_data_o holds through IDLE.
            if (r_state == ST_BUS && w_bus_done) begin
                r_err  <= bus.err;
                r_load <= (r_we | bus.err) ? '0 : w_ld_data;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             r_mis <= 1'b0;
        else if (r_state == ST_IDLE && w_access) r_mis <= w_mis;
    end
`endif

    assign bus.req     = (r_state == ST_BUS);
    assign bus.we      = r_we;
    assign bus.addr    = r_addr;
    assign bus.wdata   = r_wdata;
    assign bus.wstrb   = r_wstrb;
    assign load_data_o = r_load;
    assign bus_err_o   = (r_state == ST_DONE) & r_err;
    // Gated so stall_o is 0 while reset is held, even with an access pending.
    assign stall_o     = w_stall & rst_n;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized self-checking bench for mem_stage_lsu against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic [31:0] load_data_o;
    logic        stall_o, bus_err_o, misalign_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_lsu_if bus ();

    mem_stage_lsu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read_i  (mem_read_i),
        .mem_write_i (mem_write_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .bus         (bus.master),
        .load_data_o (load_data_o),
        .stall_o     (stall_o),
        .bus_err_o   (bus_err_o),
        .misalign_o  (misalign_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    // Access width in bytes; reserved codes are words.
    function automatic int m_bytes(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        return (a % m_bytes(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        int n, off;
        logic [31:0] v;
        n   = m_bytes(f3);
        if (n == 4) return rd;
        off = (a % 4) / n * n;
        v   = (rd >> (8 * off)) & ((32'd1 << (8 * n)) - 1);
        if (f3[2] == 1'b0 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
        return v;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (m_bytes(f3))
            1:       return (d & 32'hFF) * 32'h0101_0101;
            2:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = m_bytes(f3);
        return ((32'd1 << n) - 1) << ((a % 4) / n * n);
    endfunction

    // Entered just after a posedge with the DUT idle; returns likewise.
    task automatic do_txn(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdata, input int lat, input logic err);
        int reqs, stalls, cyc;
        logic done, mis, exp_err;
        logic [31:0] exp_ld;
        mis     = m_mis(f3, a);
        exp_err = err & ~mis;
        exp_ld  = (wr | mis | err) ? 32'h0 : m_load(f3, a, rdata);
        mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = a; wdata_i = wd;
        reqs = 0; stalls = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 30) begin
            @(negedge clk);
            if (stall_o) stalls++;
            if (bus.req) begin
                reqs++;
                if (reqs == 1) begin
                    chk("addr", bus.addr, a & 32'hFFFF_FFFC);
                    chk("we", {31'b0, bus.we}, {31'b0, wr});
                    chk("wstrb", {28'b0, bus.wstrb}, wr ? m_wstrb(f3, a) : 32'h0);
                    if (wr) chk("wdata", bus.wdata, m_wdata(f3, wd));
                end
                if (reqs == lat) begin
                    bus.rdata = rdata;
                    bus.ack   = ~err;
                    bus.err   = err;
                end
            end
            if (!stall_o) begin
                done = 1'b1;
                chk("load", load_data_o, exp_ld);
                chk("berr", {31'b0, bus_err_o}, {31'b0, exp_err});
                chk("mis", {31'b0, misalign_o}, {31'b0, mis});
                chk("reqs", reqs, mis ? 0 : lat);
                chk("stalls", stalls, mis ? 1 : lat + 1);
            end
            @(posedge clk); #1;
            bus.ack = 1'b0; bus.err = 1'b0;
            if (done) begin mem_read_i = 1'b0; mem_write_i = 1'b0; end
            cyc++;
        end
        if (!done) begin
            chk("timeout", 32'd0, 32'd1);
            mem_read_i = 1'b0; mem_write_i = 1'b0;
        end
        @(negedge clk);
        chk("berr_pulse", {31'b0, bus_err_o}, 32'h0);
        chk("hold", load_data_o, exp_ld);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0]  f3;
        logic        rd, wr;
        int          op;
        rst_n = 1'b0;
        mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b0; addr_i = '0; wdata_i = '0;
        bus.rdata = '0; bus.ack = 1'b0; bus.err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, bus.req}, 32'h0);
        chk("rst_stall", {31'b0, stall_o}, 32'h0);
        chk("rst_load", load_data_o, 32'h0);
        chk("rst_berr", {31'b0, bus_err_o}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_txn(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3, 0);
        do_txn(1, 0, 3'b000, 32'h203, 0, 32'h8012_3456, 1, 0);
        do_txn(1, 0, 3'b100, 32'h203, 0, 32'h8012_3456, 2, 0);
        do_txn(1, 0, 3'b101, 32'h202, 0, 32'hBEEF_1234, 2, 0);
        do_txn(0, 1, 3'b000, 32'h301, 32'h5A, 32'h0, 1, 0);
        do_txn(0, 1, 3'b001, 32'h302, 32'hCAFE_1234, 32'h0, 1, 0);
        do_txn(0, 1, 3'b010, 32'h300, 32'h1122_3344, 32'h0, 2, 0);
        do_txn(1, 0, 3'b010, 32'h100, 0, 32'h1357_9BDF, 2, 1);
        do_txn(1, 0, 3'b010, 32'h102, 0, 32'hA5A5_0F0F, 1, 0);
        do_txn(1, 0, 3'b001, 32'h104, 0, 32'h0000_8001, 1, 0);

        // Reset mid-BUS; the late ack must not produce a DONE.
        mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h400;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_req_pre", {31'b0, bus.req}, 32'h1);
        rst_n = 1'b0; mem_read_i = 1'b0;
        #1;
        chk("abort_req", {31'b0, bus.req}, 32'h0);
        chk("abort_stall", {31'b0, stall_o}, 32'h0);
        chk("abort_load", load_data_o, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        bus.rdata = 32'hFFFF_FFFF; bus.ack = 1'b1;
        @(posedge clk); #1;
        bus.ack = 1'b0;
        @(negedge clk);
        chk("stray_req", {31'b0, bus.req}, 32'h0);
        chk("stray_load", load_data_o, 32'h0);
        chk("stray_berr", {31'b0, bus_err_o}, 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 2);
            rd = (op != 1);
            wr = (op != 0);
            f3 = 3'($urandom_range(0, 7));
            if (wr && (f3 == 3'b100 || f3 == 3'b101)) f3 = 3'b010;
            do_txn(rd, wr, f3, $urandom, $urandom, $urandom,
                   $urandom_range(1, 4), ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
